// File: rtl/ball_motion_pkg.sv
// ball_motion_pkg: shared constants and state encoding for the ball_motion slice
// Exports the default coordinate width, the display colour width and the game FSM state type.
package ball_motion_pkg;
  localparam int POSITION_WIDTH_DEF = 11;
  localparam int COLOUR_WIDTH = 4;
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;
endpackage

// File: rtl/ball_motion_frame_tick.sv
// frame_tick: one-cycle pulse on each rising edge of vertical_sync
// Ports: pixel_clock, rst_n (async active-low), vertical_sync in; tick out.
module frame_tick (
  input  logic pixel_clock,
  input  logic rst_n,
  input  logic vertical_sync,
  output logic tick
);
  logic vs_q;
  logic primed;
  // primed masks the first sample after reset so a sync already high at release is not an edge
  always_ff @(posedge pixel_clock or negedge rst_n)
    if (!rst_n) begin
      vs_q <= 1'b0;
      primed <= 1'b0;
    end else begin
      vs_q <= vertical_sync;
      primed <= 1'b1;
    end
  assign tick = primed & vertical_sync & ~vs_q;
endmodule

// File: rtl/ball_motion.sv
// ball_motion: pong ball kinematics with serve hold, wall/paddle bounces and a miss counter
// Inputs: pixel_clock, rst_n (async active-low), vertical_sync, run, paddle_x/paddle_y (paddle top-left).
// Outputs (registered): ball_x/ball_y (centre), serving, hit/miss (one-cycle pulses), score (saturating).
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter int POSITION_WIDTH = POSITION_WIDTH_DEF,
  parameter int X_MIN = 50,
  parameter int X_MAX = 1230,
  parameter int Y_MIN = 50,
  parameter int Y_MAX = 750,
  parameter int RADIUS = 10,
  parameter int SPEED_X = 4,
  parameter int SPEED_Y = 3,
  parameter int START_X = 640,
  parameter int START_Y = 400,
  parameter int PADDLE_WIDTH = 20,
  parameter int PADDLE_LENGTH = 200,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_WIDTH = 8
) (
  input  logic                      pixel_clock,
  input  logic                      rst_n,
  input  logic                      vertical_sync,
  input  logic                      run,
  input  logic [POSITION_WIDTH-1:0] paddle_x,
  input  logic [POSITION_WIDTH-1:0] paddle_y,
  output logic [POSITION_WIDTH-1:0] ball_x,
  output logic [POSITION_WIDTH-1:0] ball_y,
  output logic                      serving,
  output logic                      hit,
  output logic                      miss,
  output logic [SCORE_WIDTH-1:0]    score
);
  localparam int W1 = POSITION_WIDTH + 1;
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [W1-1:0] XLO = W1'(X_MIN + RADIUS);
  localparam logic [W1-1:0] XHI = W1'(X_MAX - RADIUS);
  localparam logic [W1-1:0] YLO = W1'(Y_MIN + RADIUS);
  localparam logic [W1-1:0] YHI = W1'(Y_MAX - RADIUS);
  if (X_MIN + RADIUS <= SPEED_X || Y_MIN + RADIUS <= SPEED_Y ||
      START_X < X_MIN + RADIUS || START_X > X_MAX - RADIUS ||
      START_Y < Y_MIN + RADIUS || START_Y > Y_MAX - RADIUS) begin : g_illegal
    $error("ball_motion: illegal bound/speed/start parameters");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [POSITION_WIDTH-1:0] x_n, y_n;
  logic [SCORE_WIDTH-1:0] score_n;
  logic [W1-1:0] nx, ny, pedge;
  logic tick, dir_x, dir_y, serve_dy, dx_n, dy_n, sdy_n, hit_n, miss_n, pad;
  frame_tick u_frame_tick (
    .pixel_clock(pixel_clock),
    .rst_n(rst_n),
    .vertical_sync(vertical_sync),
    .tick(tick)
  );
  // widened arithmetic keeps the wall/paddle compares free of wrap-around
  assign nx = dir_x ? {1'b0, ball_x} + W1'(SPEED_X) : {1'b0, ball_x} - W1'(SPEED_X);
  assign ny = dir_y ? {1'b0, ball_y} + W1'(SPEED_Y) : {1'b0, ball_y} - W1'(SPEED_Y);
  assign pedge = {1'b0, paddle_x} + W1'(PADDLE_WIDTH);
  // ball's left edge crosses the paddle face this frame while overlapping it vertically
  assign pad = !dir_x && {1'b0, ball_x} - W1'(RADIUS) >= pedge && nx - W1'(RADIUS) <= pedge &&
               {1'b0, ball_y} + W1'(RADIUS) >= {1'b0, paddle_y} &&
               {1'b0, ball_y} - W1'(RADIUS) <= {1'b0, paddle_y} + W1'(PADDLE_LENGTH);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    x_n = ball_x;
    y_n = ball_y;
    dx_n = dir_x;
    dy_n = dir_y;
    sdy_n = serve_dy;
    score_n = score;
    hit_n = 1'b0;
    miss_n = 1'b0;
    if (run) begin
      if (state == MISS) begin
        state_n = SERVE;
        miss_n = 1'b1;
        score_n = &score ? score : score + 1'b1;
        x_n = POSITION_WIDTH'(START_X);
        y_n = POSITION_WIDTH'(START_Y);
        dx_n = 1'b1;
        sdy_n = ~serve_dy;
        dy_n = ~serve_dy;
      end else if (tick && state == SERVE) begin
        cnt_n = cnt == CW'(SERVE_FRAMES - 1) ? '0 : cnt + 1'b1;
        state_n = cnt == CW'(SERVE_FRAMES - 1) ? PLAY : SERVE;
      end else if (tick) begin
        if (ny <= YLO) begin
          y_n = POSITION_WIDTH'(Y_MIN + RADIUS);
          dy_n = 1'b1;
        end else if (ny >= YHI) begin
          y_n = POSITION_WIDTH'(Y_MAX - RADIUS);
          dy_n = 1'b0;
        end else
          y_n = ny[POSITION_WIDTH-1:0];
        if (dir_x && nx >= XHI) begin
          x_n = POSITION_WIDTH'(X_MAX - RADIUS);
          dx_n = 1'b0;
        end else if (pad) begin
          x_n = paddle_x + POSITION_WIDTH'(PADDLE_WIDTH + RADIUS);
          dx_n = 1'b1;
          hit_n = 1'b1;
        end else if (!dir_x && nx <= XLO)
          state_n = MISS;
        else
          x_n = nx[POSITION_WIDTH-1:0];
      end
    end
  end
  always_ff @(posedge pixel_clock or negedge rst_n)
    if (!rst_n) begin
      state <= SERVE;
      cnt <= '0;
      ball_x <= POSITION_WIDTH'(START_X);
      ball_y <= POSITION_WIDTH'(START_Y);
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      serve_dy <= 1'b1;
      score <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
      serving <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ball_x <= x_n;
      ball_y <= y_n;
      dir_x <= dx_n;
      dir_y <= dy_n;
      serve_dy <= sdy_n;
      score <= score_n;
      hit <= hit_n;
      miss <= miss_n;
      serving <= state_n == SERVE;
    end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed checks of serve, bounces, paddle hit, miss/score, pause and reset
module tb_ball_motion;
  logic pixel_clock = 1'b0;
  logic rst_n = 1'b0;
  logic vertical_sync = 1'b0;
  logic run = 1'b1;
  logic [10:0] pab_x = 11'd1180, pab_y = 11'd600, pc_x = 11'd0, pc_y = 11'd110;
  logic [10:0] ax, ay, bx, by, cx, cy;
  logic as, ah, am, bs, bh, bm, cs, ch, cm;
  logic [7:0] asc, bsc;
  logic [1:0] csc;
  int checks = 0;
  int failures = 0;

  always #5 pixel_clock = ~pixel_clock;

  ball_motion #(.SERVE_FRAMES(3)) ua (
    .pixel_clock(pixel_clock), .rst_n(rst_n), .vertical_sync(vertical_sync), .run(run),
    .paddle_x(pab_x), .paddle_y(pab_y), .ball_x(ax), .ball_y(ay),
    .serving(as), .hit(ah), .miss(am), .score(asc)
  );
  ball_motion #(.SERVE_FRAMES(3), .START_X(1218), .START_Y(738)) ub (
    .pixel_clock(pixel_clock), .rst_n(rst_n), .vertical_sync(vertical_sync), .run(run),
    .paddle_x(pab_x), .paddle_y(pab_y), .ball_x(bx), .ball_y(by),
    .serving(bs), .hit(bh), .miss(bm), .score(bsc)
  );
  ball_motion #(.SERVE_FRAMES(3), .X_MIN(1150), .START_X(1218), .START_Y(700), .SCORE_WIDTH(2)) uc (
    .pixel_clock(pixel_clock), .rst_n(rst_n), .vertical_sync(vertical_sync), .run(run),
    .paddle_x(pc_x), .paddle_y(pc_y), .ball_x(cx), .ball_y(cy),
    .serving(cs), .hit(ch), .miss(cm), .score(csc)
  );

  // one frame: sync high for one cycle; returns on the negedge where the tick's results are visible
  task automatic tick();
    @(negedge pixel_clock) vertical_sync = 1'b1;
    @(negedge pixel_clock) vertical_sync = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b1;
    vertical_sync = 1'b1;
    repeat (3) @(negedge pixel_clock);
    checks++;
    if ({ax, ay, as, ah, am, asc} !== {11'd640, 11'd400, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_a got (%0d,%0d) s=%b h=%b m=%b sc=%0d want (640,400) s=1 h=0 m=0 sc=0", ax, ay, as, ah, am, asc);
    end
    checks++;
    if ({bx, by, bs, bh, bm, bsc} !== {11'd1218, 11'd738, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_b got (%0d,%0d) s=%b h=%b m=%b sc=%0d want (1218,738) s=1 h=0 m=0 sc=0", bx, by, bs, bh, bm, bsc);
    end
    checks++;
    if ({cx, cy, cs, csc} !== {11'd1218, 11'd700, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_c got (%0d,%0d) s=%b sc=%0d want (1218,700) s=1 sc=0", cx, cy, cs, csc);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge pixel_clock);
    vertical_sync = 1'b0;
    repeat (2) @(negedge pixel_clock);
  endtask

  task automatic test_serve();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({ax, ay} !== {11'd640, 11'd400} || as !== (i < 3)) begin
        failures++;
        $display("FAIL serve_hold tick %0d got (%0d,%0d) s=%b want (640,400) s=%b", i, ax, ay, as, i < 3);
      end
    end
    tick();
    checks++;
    if ({ax, ay, as} !== {11'd644, 11'd403, 1'b0}) begin
      failures++;
      $display("FAIL serve_first_move got (%0d,%0d) s=%b want (644,403) s=0", ax, ay, as);
    end
  endtask

  task automatic test_corner();
    checks++;
    if ({bx, by} !== {11'd1220, 11'd740}) begin
      failures++;
      $display("FAIL corner_clamp got (%0d,%0d) want (1220,740)", bx, by);
    end
    checks++;
    if ({cx, cy} !== {11'd1220, 11'd703}) begin
      failures++;
      $display("FAIL right_wall_clamp got (%0d,%0d) want (1220,703)", cx, cy);
    end
    tick();
    checks++;
    if ({bx, by} !== {11'd1216, 11'd737}) begin
      failures++;
      $display("FAIL corner_reverse got (%0d,%0d) want (1216,737)", bx, by);
    end
    checks++;
    if ({cx, cy} !== {11'd1216, 11'd706}) begin
      failures++;
      $display("FAIL right_wall_reverse got (%0d,%0d) want (1216,706)", cx, cy);
    end
  endtask

  task automatic test_paddle();
    tick();
    checks++;
    if ({bx, by, bh} !== {11'd1212, 11'd734, 1'b0}) begin
      failures++;
      $display("FAIL paddle_approach got (%0d,%0d) hit=%b want (1212,734) hit=0", bx, by, bh);
    end
    tick();
    checks++;
    if ({bx, by, bh, bm} !== {11'd1210, 11'd731, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL paddle_hit got (%0d,%0d) hit=%b miss=%b want (1210,731) hit=1 miss=0", bx, by, bh, bm);
    end
    @(negedge pixel_clock);
    checks++;
    if (bh !== 1'b0) begin
      failures++;
      $display("FAIL paddle_hit_pulse hit=%b want 0", bh);
    end
    tick();
    checks++;
    if ({bx, by} !== {11'd1214, 11'd728}) begin
      failures++;
      $display("FAIL paddle_rebound got (%0d,%0d) want (1214,728)", bx, by);
    end
  endtask

  task automatic test_miss();
    for (int t = 9; t <= 18; t++) begin
      tick();
      checks++;
      if (cm !== 1'b0) begin
        failures++;
        $display("FAIL early_miss tick %0d miss=%b want 0", t, cm);
      end
    end
    checks++;
    if ({cx, cy} !== {11'd1164, 11'd737}) begin
      failures++;
      $display("FAIL pre_miss_pos got (%0d,%0d) want (1164,737)", cx, cy);
    end
    tick();
    @(negedge pixel_clock);
    checks++;
    if ({cm, ch, csc, cx, cy, cs} !== {1'b1, 1'b0, 2'd1, 11'd1218, 11'd700, 1'b1}) begin
      failures++;
      $display("FAIL miss_event got m=%b h=%b sc=%0d (%0d,%0d) s=%b want m=1 h=0 sc=1 (1218,700) s=1", cm, ch, csc, cx, cy, cs);
    end
    @(negedge pixel_clock);
    checks++;
    if (cm !== 1'b0) begin
      failures++;
      $display("FAIL miss_pulse miss=%b want 0", cm);
    end
  endtask

  task automatic test_serve_flip();
    repeat (3) tick();
    checks++;
    if (cs !== 1'b0) begin
      failures++;
      $display("FAIL reserve_done serving=%b want 0", cs);
    end
    tick();
    checks++;
    if ({cx, cy} !== {11'd1220, 11'd697}) begin
      failures++;
      $display("FAIL dir_y_flipped got (%0d,%0d) want (1220,697)", cx, cy);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] want;
    for (int n = 2; n <= 4; n++) begin
      repeat (n == 2 ? 15 : 19) tick();
      @(negedge pixel_clock);
      want = (n >= 3) ? 2'd3 : 2'd2;
      checks++;
      if ({cm, csc} !== {1'b1, want}) begin
        failures++;
        $display("FAIL score_saturate miss %0d got m=%b sc=%0d want m=1 sc=%0d", n, cm, csc, want);
      end
    end
  endtask

  task automatic test_pause();
    checks++;
    if ({ax, ay} !== {11'd932, 11'd619}) begin
      failures++;
      $display("FAIL pre_pause got (%0d,%0d) want (932,619)", ax, ay);
    end
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ax, ay, as} !== {11'd932, 11'd619, 1'b0}) begin
        failures++;
        $display("FAIL pause_hold tick %0d got (%0d,%0d) s=%b want (932,619) s=0", i, ax, ay, as);
      end
    end
    run = 1'b1;
    tick();
    checks++;
    if ({ax, ay} !== {11'd936, 11'd622}) begin
      failures++;
      $display("FAIL pause_resume got (%0d,%0d) want (936,622)", ax, ay);
    end
  endtask

  task automatic test_reset_mid_play();
    @(negedge pixel_clock) rst_n = 1'b0;
    #1;
    checks++;
    if ({ax, ay, as, ah, am} !== {11'd640, 11'd400, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_a got (%0d,%0d) s=%b h=%b m=%b want (640,400) s=1 h=0 m=0", ax, ay, as, ah, am);
    end
    checks++;
    if ({cx, cy, csc, cs} !== {11'd1218, 11'd700, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset_c got (%0d,%0d) sc=%0d s=%b want (1218,700) sc=0 s=1", cx, cy, csc, cs);
    end
    @(negedge pixel_clock) rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({ax, ay, as} !== {11'd640, 11'd400, 1'b1}) begin
      failures++;
      $display("FAIL restart_serve got (%0d,%0d) s=%b want (640,400) s=1", ax, ay, as);
    end
    repeat (2) tick();
    checks++;
    if ({ax, ay, as} !== {11'd644, 11'd403, 1'b0}) begin
      failures++;
      $display("FAIL restart_play got (%0d,%0d) s=%b want (644,403) s=0", ax, ay, as);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_corner();
    test_paddle();
    test_miss();
    test_serve_flip();
    test_saturate();
    test_pause();
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
